// File: rtl/stride_trie_lookup_if.sv
// Lookup / table-write bus for stride_trie_lookup.
//
// Purpose: groups the lookup request/response handshake and the runtime
// table-write port into one bundle.
//
// Signals:
//   in_valid, in_ip           lookup request and key
//   in_ready                  high once the post-reset memory clear is finished
//   out_valid                 one-cycle pulse per completed lookup
//   out_nexthop, out_hit      longest-match result (held while out_valid=0)
//   wr_en, wr_stage, wr_addr, wr_data   table write strobe, stage, {block, chunk},
//                             {exist, nexthop, child_ptr, child_valid}
//
// Modports: master = the side issuing lookups and writes, slave = the trie.
interface stride_trie_lookup_if #(
    parameter int ADDR_W = 32,
    parameter int STRIDE = 4,
    parameter int NH_W   = 8,
    parameter int PTR_W  = 8
);
    localparam int STAGES = ADDR_W / STRIDE;
    localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_W-1:0]       in_ip;
    logic                    out_valid;
    logic [NH_W-1:0]         out_nexthop;
    logic                    out_hit;
    logic                    wr_en;
    logic [SW-1:0]           wr_stage;
    logic [PTR_W+STRIDE-1:0] wr_addr;
    logic [NH_W+PTR_W+1:0]   wr_data;

    modport master (
        output in_valid, in_ip, wr_en, wr_stage, wr_addr, wr_data,
        input  in_ready, out_valid, out_nexthop, out_hit
    );

    modport slave (
        input  in_valid, in_ip, wr_en, wr_stage, wr_addr, wr_data,
        output in_ready, out_valid, out_nexthop, out_hit
    );
endinterface

// File: rtl/stride_trie_lookup.sv
// Multibit-stride longest-prefix-match pipeline.
//
// Purpose: resolves a lookup key to a next hop by walking one trie level per
// pipeline stage. Each stage owns its own node memory; an entry is
// {exist, nexthop, child_ptr, child_valid}. After reset a small state machine
// zeroes every memory before lookups and writes are accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        stride_trie_lookup_if.slave: lookup handshake, result, table writes
//   init_done  high once the memory clear has finished
module stride_trie_lookup #(
    parameter int              ADDR_W     = 32,
    parameter int              STRIDE     = 4,
    parameter int              NH_W       = 8,
    parameter int              PTR_W      = 8,
    parameter logic [NH_W-1:0] DEFAULT_NH = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    stride_trie_lookup_if.slave  bus,
    output logic                 init_done
);
    localparam int STAGES = ADDR_W / STRIDE;
    localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int AW     = PTR_W + STRIDE;          // {block, chunk}
    localparam int ENT_W  = NH_W + PTR_W + 2;

    typedef enum logic {CLEAR, RUN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] ip;
        logic [NH_W-1:0]   best_nh;
        logic              hit;
        logic [PTR_W-1:0]  ptr;
        logic              alive;
    } pipe_t;

    state_t        state, state_nx;
    logic [AW-1:0] clr_cnt, clr_cnt_nx;
    logic          accept;

    pipe_t              stage_in  [STAGES];
    pipe_t              stage_out [STAGES];
    pipe_t              pipe_q    [STAGES];
    logic [STAGES-1:0]  pipe_vld;
    logic [ENT_W-1:0]   rd        [STAGES];

    // ------------------------------------------------------------------
    // Clear / run state machine
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case statement can infer a latch.
    always_comb begin
        state_nx     = state;
        clr_cnt_nx   = clr_cnt;
        bus.in_ready = 1'b0;
        init_done    = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_cnt_nx = clr_cnt + 1'b1;
                if (&clr_cnt) state_nx = RUN;
            end
            RUN: begin
                bus.in_ready = 1'b1;
                init_done    = 1'b1;
            end
            default: state_nx = CLEAR;
        endcase
    end

    assign accept = bus.in_valid & bus.in_ready;

    // ------------------------------------------------------------------
    // Per-stage lookup. Stage 0 reads with the raw key before the accept
    // edge, so a write landing on that same edge is not yet visible to it.
    // best_nh starts at DEFAULT_NH, so it is already the miss answer.
    // ------------------------------------------------------------------
    always_comb begin
        stage_in[0] = '{ip: bus.in_ip, best_nh: DEFAULT_NH, hit: 1'b0,
                        ptr: '0, alive: 1'b1};
        for (int k = 1; k < STAGES; k++) stage_in[k] = pipe_q[k-1];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_out[k] = stage_in[k];
            if (stage_in[k].alive) begin
                if (rd[k][ENT_W-1]) begin
                    stage_out[k].best_nh = rd[k][ENT_W-2 -: NH_W];
                    stage_out[k].hit     = 1'b1;
                end
                stage_out[k].ptr = rd[k][PTR_W:1];
                // The last stage has no children, so its child_valid is moot.
                if (!rd[k][0] && k != STAGES - 1) stage_out[k].alive = 1'b0;
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // The root stage only ever addresses block 0, so it stores one block.
        localparam int IW = (k == 0) ? STRIDE : AW;

        logic [ENT_W-1:0] mem [2**IW];
        logic [IW-1:0]    rd_addr;
        logic             wr_sel;

        if (k == 0) begin : g_root
            assign rd_addr = stage_in[0].ip[ADDR_W-1 -: STRIDE];
            assign wr_sel  = bus.wr_en && (bus.wr_stage == '0)
                             && (bus.wr_addr[AW-1:STRIDE] == '0);
        end else begin : g_inner
            assign rd_addr = {stage_in[k].ptr,
                              stage_in[k].ip[ADDR_W-1-k*STRIDE -: STRIDE]};
            assign wr_sel  = bus.wr_en && (bus.wr_stage == SW'(k));
        end

        assign rd[k] = mem[rd_addr];

        // NOTE: the node memory has no reset; it is zeroed by the CLEAR
        // sweep instead, which keeps it mappable onto RAM.
        always_ff @(posedge clk) begin
            if (state == CLEAR)
                mem[clr_cnt[IW-1:0]] <= '0;
            else if (wr_sel)
                mem[bus.wr_addr[IW-1:0]] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: only the valid bits need a defined reset value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int k = 1; k < STAGES; k++) pipe_vld[k] <= pipe_vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) pipe_q[k] <= stage_out[k];
    end

    // Result register: nexthop/hit hold their last value across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_nexthop <= DEFAULT_NH;
            bus.out_hit     <= 1'b0;
        end else begin
            bus.out_valid <= pipe_vld[STAGES-1];
            if (pipe_vld[STAGES-1]) begin
                bus.out_nexthop <= pipe_q[STAGES-1].best_nh;
                bus.out_hit     <= pipe_q[STAGES-1].hit;
            end
        end
    end
endmodule

// File: tb/tb_stride_trie_lookup.sv
// Self-checking bench for stride_trie_lookup at default parameters.
// Directed steps plus randomized write/lookup rounds; expected results come
// from a table-walk reference model over an associative array.
module tb_stride_trie_lookup;
    localparam int ADDR_W = 32;
    localparam int STRIDE = 4;
    localparam int NH_W   = 8;
    localparam int PTR_W  = 8;
    localparam int STAGES = ADDR_W / STRIDE;
    localparam int LAT    = STAGES;
    localparam int DEPTH  = 1 << (PTR_W + STRIDE);
    localparam logic [NH_W-1:0] DEF_NH = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic init_done;

    always #5 clk = ~clk;

    stride_trie_lookup_if #(.ADDR_W(ADDR_W), .STRIDE(STRIDE), .NH_W(NH_W), .PTR_W(PTR_W)) bus ();

    stride_trie_lookup #(
        .ADDR_W(ADDR_W), .STRIDE(STRIDE), .NH_W(NH_W), .PTR_W(PTR_W), .DEFAULT_NH(DEF_NH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done)
    );

    typedef struct {
        logic [31:0] ip;
        logic [7:0]  nh;
        logic        hit;
        int          acc;
    } exp_t;

    exp_t        sb [$];
    logic [17:0] ref_mem [int];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  last_nh  = DEF_NH;
    logic        last_hit = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] ent(input bit ex, input logic [7:0] nh,
                                        input logic [7:0] ptr, input bit cv);
        return {ex, nh, ptr, cv};
    endfunction

    function automatic logic [17:0] mem_get(input int st, input int addr);
        int key = st * DEPTH + addr;
        if (ref_mem.exists(key)) return ref_mem[key];
        return 18'h0;
    endfunction

    // Walk the trie from the root, remembering the deepest matching prefix.
    function automatic logic [8:0] model_lookup(input logic [31:0] ip);
        logic [7:0]  nh  = DEF_NH;
        logic        hit = 1'b0;
        int          ptr = 0;
        int          chunk;
        logic [17:0] e;
        for (int k = 0; k < STAGES; k++) begin
            chunk = int'((ip >> (ADDR_W - STRIDE * (k + 1))) & 32'hF);
            e = mem_get(k, ptr * 16 + chunk);
            if (e[17]) begin
                nh  = e[16:9];
                hit = 1'b1;
            end
            if (k == STAGES - 1 || !e[0]) break;
            ptr = int'(e[8:1]);
        end
        return {hit, nh};
    endfunction

    // Input setters act on the next rising edge; tick() advances one cycle.
    task automatic set_lookup_exp(input logic [31:0] ip, input logic [7:0] nh, input logic hit);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_ip    = ip;
        e.ip = ip; e.nh = nh; e.hit = hit; e.acc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic set_lookup(input logic [31:0] ip);
        logic [8:0] r = model_lookup(ip);
        set_lookup_exp(ip, r[7:0], r[8]);
    endtask

    task automatic set_write(input int st, input logic [11:0] wa, input logic [17:0] wd);
        bus.wr_en    = 1'b1;
        bus.wr_stage = 3'(st);
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        if (st < STAGES && !(st == 0 && wa[11:4] != 8'h0))
            ref_mem[st * DEPTH + int'(wa)] = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.wr_en    = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        bit quiet = 1'b1;
        while (init_done !== 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (init_done !== 1'b1 && (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)) quiet = 1'b0;
        end
        check("init_cycles", 64'(n), 64'(DEPTH));
        check("pre_init_quiet", 64'(quiet), 64'd1);
        check("in_ready_after_init", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: order, value, latency and hold-between-pulses checks.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            last_nh  = DEF_NH;
            last_hit = 1'b0;
        end else if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("nexthop ip=%08h", e.ip), 64'(bus.out_nexthop), 64'(e.nh));
                check($sformatf("hit ip=%08h", e.ip), 64'(bus.out_hit), 64'(e.hit));
                check($sformatf("latency ip=%08h", e.ip), 64'(cyc - e.acc), 64'(LAT));
                last_nh  = e.nh;
                last_hit = e.hit;
            end
        end else begin
            check("hold_nexthop", 64'(bus.out_nexthop), 64'(last_nh));
            check("hold_hit", 64'(bus.out_hit), 64'(last_hit));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] golden [20];
        logic [11:0] wa;
        int          st;

        bus.in_valid = 1'b0; bus.in_ip   = '0;
        bus.wr_en    = 1'b0; bus.wr_stage = '0;
        bus.wr_addr  = '0;   bus.wr_data  = '0;

        // Reset state
        #22;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_nexthop", 64'(bus.out_nexthop), 64'(DEF_NH));
        check("rst_out_hit", 64'(bus.out_hit), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_init();

        // Empty table misses
        set_lookup_exp(32'h0A000001, 8'h00, 1'b0); tick();
        drain();

        // Single /4 route
        set_write(0, 12'h00A, ent(1'b1, 8'h05, 8'h00, 1'b0)); tick();
        set_lookup_exp(32'hA1234567, 8'h05, 1'b1); tick();
        set_lookup_exp(32'hB0000000, 8'h00, 1'b0); tick();
        drain();

        // Longest match across two stages
        set_write(0, 12'h00A, ent(1'b1, 8'h05, 8'h03, 1'b1)); tick();
        set_write(1, 12'h031, ent(1'b1, 8'h07, 8'h00, 1'b0)); tick();
        set_lookup_exp(32'hA1000000, 8'h07, 1'b1); tick();
        set_lookup_exp(32'hA2000000, 8'h05, 1'b1); tick();
        set_lookup_exp(32'h0A0A1000, 8'h00, 1'b0); tick();
        drain();

        // Back-to-back, then again with one bubble in the middle
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0: golden[i] = 32'hA1000000 | 32'($urandom_range(0, 32'hFFFFFF));
                1: golden[i] = 32'hA2000000 | 32'($urandom_range(0, 32'hFFFFFF));
                2: golden[i] = 32'h0B000000 | 32'($urandom_range(0, 32'hFFFFFF));
                default: golden[i] = $urandom;
            endcase
        end
        for (int i = 0; i < 20; i++) begin set_lookup(golden[i]); tick(); end
        drain();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) tick();
            set_lookup(golden[19 - i]); tick();
        end
        drain();

        // Write and lookup on the same edge: the lookup sees the old entry
        set_lookup_exp(32'hA0000000, 8'h05, 1'b1);
        set_write(0, 12'h00A, ent(1'b1, 8'h09, 8'h03, 1'b1));
        tick();
        set_lookup_exp(32'hA0000000, 8'h09, 1'b1); tick();
        drain();

        // Randomized rounds: writes, then a lookup burst with bubbles
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 40; w++) begin
                st = $urandom_range(0, STAGES - 1);
                if (st == 0)
                    wa = ($urandom_range(0, 9) == 0) ? {8'($urandom_range(1, 255)), 4'($urandom)}
                                                     : {8'h00, 4'($urandom)};
                else
                    wa = {8'($urandom_range(0, 3)), 4'($urandom)};
                set_write(st, wa, ent(1'($urandom_range(0, 1)), 8'($urandom),
                                      8'($urandom_range(0, 3)), $urandom_range(0, 3) != 0));
                tick();
            end
            for (int l = 0; l < 24; l++) begin
                if ($urandom_range(0, 4) == 0) tick();
                else begin set_lookup($urandom); tick(); end
            end
            drain();
        end

        // Async reset with four lookups in flight
        set_write(0, 12'h00B, ent(1'b1, 8'h44, 8'h00, 1'b0)); tick();
        for (int i = 0; i < 4; i++) begin set_lookup(32'hA1000000 + 32'(i)); tick(); end
        #2;
        rst = 1'b0;
        sb.delete();
        ref_mem.delete();
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("async_rst_init_done", 64'(init_done), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;          // must be ignored throughout CLEAR
        bus.in_ip    = 32'hA1000000;
        wait_init();
        bus.in_valid = 1'b0;
        set_lookup_exp(32'hA1000000, 8'h00, 1'b0); tick();
        set_lookup_exp(32'hA1234567, 8'h00, 1'b0); tick();
        set_lookup_exp(32'hB0000000, 8'h00, 1'b0); tick();
        drain();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
